// File: rtl/dmem_resp.sv
// Single-port data-memory responder with a fixed-latency IDLE/WAIT/RESP handshake.
// Define DMEM_ERR_EN to add the mem_err output with range and alignment checking.
module dmem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_wmask,
    output logic        mem_ready,
    output logic        mem_resp_valid,
    output logic [31:0] mem_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic        mem_err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;
    logic        enter_resp;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        req_ren;
    logic        req_wen;
    logic        req_err;
    logic        acc_err;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [3:0]    lanes;
    logic [31:0]   wdata_sh;
    logic          is_store;
    logic          is_load;

    // A store wins when both enables are set; neither set is a no-op.
    assign is_store = req_wen;
    assign is_load  = req_ren & ~req_wen;

    assign idx      = AW'((req_addr - BASE_ADDR) >> 2);
    // Lanes shifted past byte 3 fall off the 4-bit truncation.
    assign lanes    = 4'(req_wmask << req_addr[1:0]);
    assign wdata_sh = req_wdata << {req_addr[1:0], 3'b000};

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        mem_ready      = 1'b0;
        mem_resp_valid = 1'b0;
        accept         = 1'b0;
        enter_resp     = 1'b0;
        case (state)
            IDLE: begin
                mem_ready = 1'b1;
                if (mem_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = 4'd0;
                end
            end
            WAIT: begin
                if (cnt == 4'(LATENCY - 1)) begin
                    state_nxt  = RESP;
                    cnt_nxt    = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RESP: begin
                mem_resp_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Load data is fetched on the edge into RESP so it is valid for the whole strobe.
            if (enter_resp) begin
                if (req_err)
                    mem_rdata <= 32'd0;
                else if (is_load)
                    mem_rdata <= mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
            req_wmask <= mem_wmask;
            req_ren   <= mem_ren;
            req_wen   <= mem_wen;
            req_err   <= acc_err;
        end
    end

    // Storage is never reset; an async reset leaves RESP before this edge can write.
    always_ff @(posedge clk) begin
        if (state == RESP && is_store && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i])
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

`ifdef DMEM_ERR_EN
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

    logic [31:0] off_in;
    assign off_in = mem_addr - BASE_ADDR;

    // Addresses below BASE_ADDR wrap to large offsets and fail the same compare.
    always_comb begin
        acc_err = 1'b0;
        if (mem_ren | mem_wen) begin
            if (off_in >= LIMIT)
                acc_err = 1'b1;
            if (mem_wmask == 8'h03 && mem_addr[0])
                acc_err = 1'b1;
            if (mem_wmask == 8'h0F && mem_addr[1:0] != 2'b00)
                acc_err = 1'b1;
        end
    end

    assign mem_err = (state == RESP) & req_err;
`else
    assign acc_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: handshake timing, byte-lane stores, wrapping, reset abort.
module tb_dmem_resp;

    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [7:0]  mem_wmask = 8'd0;
    logic        mem_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
`ifdef DMEM_ERR_EN
    logic        mem_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_resp #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_valid     (mem_valid),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_ready     (mem_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata)
`ifdef DMEM_ERR_EN
        ,
        .mem_err       (mem_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request; returns strobe cycle count after accept (0 = no strobe), rdata and err at strobe.
    task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [7:0] m, output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_ren   = r;
        mem_wen   = w;
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        chk("ready_idle", {31'd0, mem_ready}, 32'd1);
        @(posedge clk);
        #1 mem_valid = 1'b0;
        lat = 0;
        rd  = 32'd0;
        er  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_resp_valid === 1'b1) begin
                lat = i;
                rd  = mem_rdata;
`ifdef DMEM_ERR_EN
                er  = mem_err;
`endif
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          acc;
        logic        seen;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_resp_valid", {31'd0, mem_resp_valid}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("ready_after_rst", {31'd0, mem_ready}, 32'd1);

        // Word store then load, with latency
        xact(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, lat, rd, er);
        chk("sw_latency", 32'(lat), 32'(LAT + 1));
        xact(1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h0F, lat, rd, er);
        chk("lw_latency", 32'(lat), 32'(LAT + 1));
        chk("lw_deadbeef", rd, 32'hDEAD_BEEF);

        // Byte store into lane 3
        xact(1'b0, 1'b1, 32'h8000_0010, 32'h1122_3344, 8'h0F, lat, rd, er);
        xact(1'b0, 1'b1, 32'h8000_0013, 32'h0000_00AA, 8'h01, lat, rd, er);
        xact(1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h0F, lat, rd, er);
        chk("sb_lane3", rd, 32'hAA22_3344);

        // Half store into upper half; rdata holds across store responses
        xact(1'b0, 1'b1, 32'h8000_0020, 32'h0, 8'h0F, lat, rd, er);
        xact(1'b0, 1'b1, 32'h8000_0022, 32'h0000_BEEF, 8'h03, lat, rd, er);
        chk("rdata_hold_store", rd, 32'hAA22_3344);
        xact(1'b1, 1'b0, 32'h8000_0020, 32'h0, 8'h0F, lat, rd, er);
        chk("sh_upper", rd, 32'hBEEF_0000);

`ifndef DMEM_ERR_EN
        // Address beyond the array wraps onto word 4
        xact(1'b0, 1'b1, 32'h8000_1010, 32'h1234_5678, 8'h0F, lat, rd, er);
        xact(1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h0F, lat, rd, er);
        chk("addr_wrap", rd, 32'h1234_5678);

        // Misaligned word: lanes past byte 3 are dropped, next word untouched
        xact(1'b0, 1'b1, 32'h8000_0034, 32'h5555_5555, 8'h0F, lat, rd, er);
        xact(1'b0, 1'b1, 32'h8000_0030, 32'h0, 8'h0F, lat, rd, er);
        xact(1'b0, 1'b1, 32'h8000_0032, 32'hCAFE_F00D, 8'h0F, lat, rd, er);
        xact(1'b1, 1'b0, 32'h8000_0030, 32'h0, 8'h0F, lat, rd, er);
        chk("cross_drop", rd, 32'hF00D_0000);
        xact(1'b1, 1'b0, 32'h8000_0034, 32'h0, 8'h0F, lat, rd, er);
        chk("cross_next_word", rd, 32'h5555_5555);
`else
        xact(1'b0, 1'b1, 32'h8000_0010, 32'h1234_5678, 8'h0F, lat, rd, er);
        xact(1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h0F, lat, rd, er);
        chk("lw_1234", rd, 32'h1234_5678);
`endif

        // ren & wen together act as a store; neither is a no-op with a strobe
        xact(1'b1, 1'b1, 32'h8000_0040, 32'h0BAD_CAFE, 8'h0F, lat, rd, er);
        xact(1'b1, 1'b0, 32'h8000_0040, 32'h0, 8'h0F, lat, rd, er);
        chk("both_is_store", rd, 32'h0BAD_CAFE);
        xact(1'b0, 1'b0, 32'h8000_0040, 32'hFFFF_FFFF, 8'h0F, lat, rd, er);
        chk("noop_latency", 32'(lat), 32'(LAT + 1));
        chk("noop_rdata_hold", rd, 32'h0BAD_CAFE);
        xact(1'b1, 1'b0, 32'h8000_0040, 32'h0, 8'h0F, lat, rd, er);
        chk("noop_no_write", rd, 32'h0BAD_CAFE);

        // mem_valid held high: one accept every LAT+2 cycles
        @(negedge clk);
        mem_valid = 1'b1;
        mem_ren   = 1'b1;
        mem_wen   = 1'b0;
        mem_addr  = 32'h8000_0010;
        mem_wmask = 8'h0F;
        acc = 0;
        for (int i = 0; i < 3 * (LAT + 2); i++) begin
            if (i > 0) @(negedge clk);
            chk("cont_ready", {31'd0, mem_ready}, {31'd0, (i % (LAT + 2)) == 0});
            chk("cont_resp", {31'd0, mem_resp_valid}, {31'd0, (i % (LAT + 2)) == (LAT + 1)});
            if (mem_ready === 1'b1) acc++;
            if (i == LAT + 1) chk("cont_rdata", mem_rdata, 32'h1234_5678);
        end
        mem_valid = 1'b0;
        chk("cont_accepts", 32'(acc), 32'd3);

        // Reset during WAIT of a store: async output reset, no strobe, no write
        @(negedge clk);
        mem_valid = 1'b1;
        mem_ren   = 1'b0;
        mem_wen   = 1'b1;
        mem_addr  = 32'h8000_0010;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wmask = 8'h0F;
        @(posedge clk);
        #1 mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_resp_valid", {31'd0, mem_resp_valid}, 32'd0);
        chk("abort_rdata", mem_rdata, 32'd0);
        chk("abort_ready", {31'd0, mem_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_resp_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_strobe", {31'd0, seen}, 32'd0);
        xact(1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h0F, lat, rd, er);
        chk("abort_old_data", rd, 32'h1234_5678);

`ifdef DMEM_ERR_EN
        xact(1'b0, 1'b1, BASE, 32'h0102_0304, 8'h0F, lat, rd, er);
        chk("err_ok_store", {31'd0, er}, 32'd0);
        xact(1'b1, 1'b0, 32'h8000_0002, 32'h0, 8'h0F, lat, rd, er);
        chk("err_misalign", {31'd0, er}, 32'd1);
        chk("err_misalign_rdata", rd, 32'd0);
        xact(1'b0, 1'b1, BASE + 32'd4096, 32'hFFFF_FFFF, 8'h0F, lat, rd, er);
        chk("err_range", {31'd0, er}, 32'd1);
        xact(1'b1, 1'b0, BASE, 32'h0, 8'h0F, lat, rd, er);
        chk("err_no_write", rd, 32'h0102_0304);
        chk("err_clear", {31'd0, er}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
